pad_motion_ctrl: RTL and testbench
==================================

Name: pad_motion_ctrl

Overview:
- Parametrised successor to the single-speed player pad controller.
- Drives one pong pad's top-edge Y coordinate with direction-aware acceleration and saturating boundary clamping.
- Supports a synchronous recentre request and an optional AI tracking mode that follows the ball.
- Sits between input decoding (buttons/keyboard) or ball logic and the pad draw stage; one instance per pad.

Parameters:
PAD_HEIGHT, 145, pad height in pixels
Y_RESET, 312, top-edge position after reset/recentre
Y_MARGIN, 2, minimum gap kept to top and bottom screen edges
V_MIN, 1, starting speed in px per tick
V_MAX, 6, maximum player speed in px per tick
ACCEL_TICKS, 4, consecutive moving ticks before speed increments by 1
AI_V_MAX, 3, speed cap in AI mode
DEADBAND, 8, AI dead zone half-width in pixels

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
timing_tick  in  1  one-cycle frame/motion strobe
up  in  1  player move-up request
down  in  1  player move-down request
recenter  in  1  synchronous request to return the pad to Y_RESET
ai_mode  in  1  1 = AI drives pad (only with PAD_AI_EN)
ball_y  in  10  ball centre Y (only used with PAD_AI_EN)
y_pad  out  10  pad top-edge Y
at_top  out  1  y_pad == Y_LO
at_bottom  out  1  y_pad == Y_HI
moving  out  1  FSM in UP or DOWN

Behaviour:
- Limits: Y_LO = Y_MARGIN; Y_HI = VER_PIXELS - PAD_HEIGHT - Y_MARGIN, with VER_PIXELS = 768 from vga_pkg, giving Y_HI = 621.
- Reset (async, rst=1): y_pad=Y_RESET, FSM=IDLE, speed=V_MIN, tick counter=0, at_top=0, at_bottom=0, moving=0.
- All outputs are registered. State changes only on cycles with timing_tick=1, except recenter.
- Effective request: up_req = up & ~down; down_req = down & ~up. up and down together mean no request.
- FSM states: IDLE, UP, DOWN.
- IDLE: no move.
  - On a tick with up_req, go to UP and move by V_MIN that same tick.
  - On a tick with down_req, go to DOWN and move by V_MIN that same tick.
- UP/DOWN, on each tick with the same request:
  - Move by the current speed.
  - Increment the counter. When the counter reaches ACCEL_TICKS, clear it and set speed = min(speed+1, cap). cap = V_MAX, or AI_V_MAX in AI mode.
- UP/DOWN, on a tick where the request is released, both are asserted, or the direction reverses:
  - Go to IDLE with no move that tick.
  - Reset speed to V_MIN and the counter to 0.
  - A reversal starts moving in the new direction on the following tick.
- Arithmetic: compute next position in 11 bits, then saturate to [Y_LO, Y_HI]. No wrap-around is permitted.
- Clamp hit: y_pad is set to the limit, speed resets to V_MIN, counter is cleared, and the FSM stays in UP/DOWN. Further ticks in that direction hold at the limit.
- at_top and at_bottom are registered from the new y_pad, so they change in the same cycle as y_pad.
- recenter: on the next clock edge y_pad=Y_RESET, FSM=IDLE, speed=V_MIN, counter=0, regardless of timing_tick. recenter has priority over any move.
- Reset mid-move returns immediately to the reset values.

Optional Feature:
PAD_AI_EN
- Defined:
  - The tracker sub-module produces registered requests, one clock of latency, from ball_y versus pad centre c = y_pad + PAD_HEIGHT/2.
  - ball_y > c+DEADBAND gives down; ball_y < c-DEADBAND gives up; otherwise no request.
  - When ai_mode=1, the tracker requests replace up/down and the cap is AI_V_MAX.
- Undefined: ai_mode and ball_y are ignored, no tracker logic is built, and the cap is always V_MAX.

Decomposition:
- pad_pkg holds:
  - typedef enum logic [1:0] pad_state_t {IDLE, UP, DOWN}
  - Default PAD_HEIGHT, Y_RESET, Y_MARGIN
  - Speed and deadband defaults
- VER_PIXELS comes from vga_pkg.
- One sub-module, pad_ai_tracker: computes the centre, applies the deadband comparison, and registers up_req/down_req. It is instantiated only under PAD_AI_EN.

Test Plan:
1. Reset then hold down for 8 ticks (ACCEL_TICKS=4) -> y_pad 313,314,315,316,318,320,322,324; moving=1.
2. From 312, hold down continuously until the limit -> y_pad saturates at exactly 621, at_bottom=1, never exceeds 621; hold 3 more ticks -> still 621.
3. Hold up from y_pad=4 at speed 1, then continue -> 3, 2, 2; at_top=1; no wrap to ~1023.
4. Down for 5 ticks, then up and down together for 1 tick, then up -> no move on the conflict tick, FSM=IDLE, next up tick moves by 1.
5. recenter asserted without a tick while y_pad=500 -> y_pad=312 next clock, moving=0; assert rst mid-move -> y_pad=312 immediately.
6. PAD_AI_EN, ai_mode=1, y_pad=312 (centre 384), ball_y=500 -> pad moves down and speed caps at 3; ball_y=390 -> no motion (inside deadband).

Source files
------------

// File: rtl/pad_pkg.sv
// Shared types and default geometry/speed settings for the pad motion controller.
// Latency: none (types and constants only).
// Backpressure: none.
package pad_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } pad_state_t;

   // Geometry defaults
   localparam int PAD_HEIGHT_DEF  = 145;
   localparam int Y_RESET_DEF     = 312;
   localparam int Y_MARGIN_DEF    = 2;

   // Speed and AI tracking defaults
   localparam int V_MIN_DEF       = 1;
   localparam int V_MAX_DEF       = 6;
   localparam int ACCEL_TICKS_DEF = 4;
   localparam int AI_V_MAX_DEF    = 3;
   localparam int DEADBAND_DEF    = 8;

endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video pipeline and the game objects.
// Latency: none (constants only).
// Backpressure: none.
package vga_pkg;

   localparam int HOR_PIXELS = 1024;
   localparam int VER_PIXELS = 768;

endpackage

// File: rtl/pad_ai_tracker.sv
// Ball follower: compares ball_y with the pad centre and emits up/down requests.
// Latency: 1 clk (requests are registered from the current ball_y and y_pad).
// Backpressure: none; requests are level signals sampled by the motion FSM on its ticks.
module pad_ai_tracker
   import pad_pkg::*;
#(
   parameter int PAD_HEIGHT = PAD_HEIGHT_DEF,
   parameter int DEADBAND   = DEADBAND_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] ball_y,
   input  logic [9:0] y_pad,
   output logic       up_req,
   output logic       down_req
);

   logic [10:0] centre;
   logic [10:0] ball_ext;

   // 11-bit arithmetic so centre + deadband never wraps near the bottom edge
   assign centre   = {1'b0, y_pad} + 11'(PAD_HEIGHT / 2);
   assign ball_ext = {1'b0, ball_y};

   // Deadband comparison; the lower bound is written as ball+DB < centre to avoid underflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_req   <= 1'b0;
         down_req <= 1'b0;
      end else begin
         down_req <= (ball_ext > (centre + 11'(DEADBAND)));
         up_req   <= ((ball_ext + 11'(DEADBAND)) < centre);
      end
   end

endmodule

// File: rtl/pad_motion_ctrl.sv
// Pong pad top-edge position with acceleration, saturating clamp, recentre and optional AI (PAD_AI_EN).
// Latency: 1 clk; y_pad/at_top/at_bottom/moving update on the edge that samples timing_tick or recenter.
// Backpressure: none; inputs are levels sampled only on timing_tick cycles (recenter on any cycle).
module pad_motion_ctrl
   import pad_pkg::*;
   import vga_pkg::*;
#(
   parameter int PAD_HEIGHT  = PAD_HEIGHT_DEF,
   parameter int Y_RESET     = Y_RESET_DEF,
   parameter int Y_MARGIN    = Y_MARGIN_DEF,
   parameter int V_MIN       = V_MIN_DEF,
   parameter int V_MAX       = V_MAX_DEF,
   parameter int ACCEL_TICKS = ACCEL_TICKS_DEF,
   parameter int AI_V_MAX    = AI_V_MAX_DEF,
   parameter int DEADBAND    = DEADBAND_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timing_tick,
   input  logic       up,
   input  logic       down,
   input  logic       recenter,
   input  logic       ai_mode,
   input  logic [9:0] ball_y,
   output logic [9:0] y_pad,
   output logic       at_top,
   output logic       at_bottom,
   output logic       moving
);

   // Speed field only needs to hold the player cap; the AI cap is never larger
   localparam int SW = $clog2(V_MAX + 1);
   localparam int CW = $clog2(ACCEL_TICKS + 1);

   localparam logic [9:0]    Y_LO_P  = 10'(Y_MARGIN);
   localparam logic [9:0]    Y_HI_P  = 10'(VER_PIXELS - PAD_HEIGHT - Y_MARGIN);
   localparam logic [9:0]    Y_RST_P = 10'(Y_RESET);
   localparam logic [SW-1:0] V_MIN_S = SW'(V_MIN);
   localparam logic [CW-1:0] ACCEL_S = CW'(ACCEL_TICKS);

   pad_state_t    state;
   logic [SW-1:0] speed;
   logic [CW-1:0] cnt;

   logic          up_src, down_src;
   logic          up_req, down_req;
   logic [SW-1:0] cap;

`ifdef PAD_AI_EN
   logic ai_up, ai_down;

   pad_ai_tracker #(
      .PAD_HEIGHT (PAD_HEIGHT),
      .DEADBAND   (DEADBAND)
   ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .ball_y   (ball_y),
      .y_pad    (y_pad),
      .up_req   (ai_up),
      .down_req (ai_down)
   );

   assign up_src   = ai_mode ? ai_up   : up;
   assign down_src = ai_mode ? ai_down : down;
   assign cap      = ai_mode ? SW'(AI_V_MAX) : SW'(V_MAX);
`else
   logic unused_ai;

   assign unused_ai = ^{ai_mode, ball_y};
   assign up_src    = up;
   assign down_src  = down;
   assign cap       = SW'(V_MAX);
`endif

   // Both directions at once cancel out
   assign up_req   = up_src & ~down_src;
   assign down_req = down_src & ~up_src;

   logic [10:0]   pos_up, pos_dn;
   logic          hit_top, hit_bot;
   logic [CW-1:0] cnt_inc;

   // Next position in 11 bits: bit 10 set on the up path flags an underflow below zero
   assign pos_up  = {1'b0, y_pad} - 11'(speed);
   assign pos_dn  = {1'b0, y_pad} + 11'(speed);
   assign hit_top = pos_up[10] || (pos_up[9:0] <= Y_LO_P);
   assign hit_bot = (pos_dn >= {1'b0, Y_HI_P});
   assign cnt_inc = cnt + 1'b1;

   logic          go;
   logic [9:0]    mv_y;
   logic [SW-1:0] mv_spd;
   logic [CW-1:0] mv_cnt;

   // Decide whether this tick moves: start from IDLE or continue in the same direction
   always_comb begin
      go = 1'b0;
      unique case (state)
         IDLE:    go = up_req | down_req;
         UP:      go = up_req;
         DOWN:    go = down_req;
         default: go = 1'b0;
      endcase
   end

   // Position, speed and counter after a move; a clamp hit parks at the limit at base speed
   always_comb begin
      mv_y   = y_pad;
      mv_spd = speed;
      mv_cnt = cnt;
      if (up_req ? hit_top : hit_bot) begin
         mv_y   = up_req ? Y_LO_P : Y_HI_P;
         mv_spd = V_MIN_S;
         mv_cnt = '0;
      end else begin
         mv_y = up_req ? pos_up[9:0] : pos_dn[9:0];
         if (cnt_inc == ACCEL_S) begin
            mv_cnt = '0;
            mv_spd = (speed < cap) ? speed + 1'b1 : cap;
         end else begin
            mv_cnt = cnt_inc;
         end
      end
   end

   // Motion FSM with registered outputs; recenter overrides any tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         y_pad     <= Y_RST_P;
         speed     <= V_MIN_S;
         cnt       <= '0;
         moving    <= 1'b0;
         at_top    <= (Y_RST_P == Y_LO_P);
         at_bottom <= (Y_RST_P == Y_HI_P);
      end else if (recenter) begin
         state     <= IDLE;
         y_pad     <= Y_RST_P;
         speed     <= V_MIN_S;
         cnt       <= '0;
         moving    <= 1'b0;
         at_top    <= (Y_RST_P == Y_LO_P);
         at_bottom <= (Y_RST_P == Y_HI_P);
      end else if (timing_tick) begin
         if (go) begin
            state     <= up_req ? UP : DOWN;
            moving    <= 1'b1;
            y_pad     <= mv_y;
            speed     <= mv_spd;
            cnt       <= mv_cnt;
            at_top    <= (mv_y == Y_LO_P);
            at_bottom <= (mv_y == Y_HI_P);
         end else if (state != IDLE) begin
            // Release, conflict or reversal: stop this tick without moving
            state  <= IDLE;
            moving <= 1'b0;
            speed  <= V_MIN_S;
            cnt    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pad_motion_ctrl.sv
// Self-checking bench for pad_motion_ctrl: directed steps with a scoreboard of expected outputs.
// Latency: expectations are queued when a tick/recenter is driven and popped one clock later.
// Backpressure: none; every wait is a fixed number of clock edges.
module tb_pad_motion_ctrl;

   localparam int YLO    = 2;
   localparam int YHI    = 768 - 145 - 2;
   localparam int YRST   = 312;
   localparam int ACCEL  = 4;
   localparam int HALF_H = 145 / 2;
   localparam int DBAND  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       timing_tick;
   logic       up;
   logic       down;
   logic       recenter;
   logic       ai_mode;
   logic [9:0] ball_y;
   logic [9:0] y_pad;
   logic       at_top;
   logic       at_bottom;
   logic       moving;

   pad_motion_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .timing_tick (timing_tick),
      .up          (up),
      .down        (down),
      .recenter    (recenter),
      .ai_mode     (ai_mode),
      .ball_y      (ball_y),
      .y_pad       (y_pad),
      .at_top      (at_top),
      .at_bottom   (at_bottom),
      .moving      (moving)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      bit top;
      bit bot;
      bit mv;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   // Reference model of the pad: position, state (0 idle, 1 up, 2 down), speed, run counter
   int m_y, m_st, m_spd, m_cnt;

   function automatic void model_reset();
      m_y   = YRST;
      m_st  = 0;
      m_spd = 1;
      m_cnt = 0;
   endfunction

   function automatic void model_move(bit go_up, int cap);
      int t;
      t = go_up ? (m_y - m_spd) : (m_y + m_spd);
      if (go_up && t <= YLO) begin
         m_y = YLO; m_spd = 1; m_cnt = 0;
      end else if (!go_up && t >= YHI) begin
         m_y = YHI; m_spd = 1; m_cnt = 0;
      end else begin
         m_y   = t;
         m_cnt = m_cnt + 1;
         if (m_cnt == ACCEL) begin
            m_cnt = 0;
            if (m_spd < cap) m_spd = m_spd + 1;
         end
      end
   endfunction

   function automatic void model_tick(bit u, bit d, int cap);
      bit ur, dr;
      ur = u && !d;
      dr = d && !u;
      if (m_st == 0) begin
         if (ur) begin
            m_st = 1; model_move(1'b1, cap);
         end else if (dr) begin
            m_st = 2; model_move(1'b0, cap);
         end
      end else if ((m_st == 1 && ur) || (m_st == 2 && dr)) begin
         model_move(m_st == 1, cap);
      end else begin
         m_st = 0; m_spd = 1; m_cnt = 0;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.y   = m_y;
      e.top = (m_y == YLO);
      e.bot = (m_y == YHI);
      e.mv  = (m_st != 0);
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_y"},   32'(y_pad),     32'(e.y));
         check({tag, "_top"}, 32'(at_top),    32'(e.top));
         check({tag, "_bot"}, 32'(at_bottom), 32'(e.bot));
         check({tag, "_mv"},  32'(moving),    32'(e.mv));
      end
   endtask

   task automatic tick(input string tag, input bit u, input bit d);
      @(negedge clk);
      up = u; down = d; timing_tick = 1'b1;
      model_tick(u, d, 6);
      push_exp();
      @(posedge clk); #1;
      timing_tick = 1'b0;
      pop_cmp(tag);
   endtask

   task automatic do_recenter(input string tag);
      @(negedge clk);
      recenter = 1'b1;
      model_reset();
      push_exp();
      @(posedge clk); #1;
      recenter = 1'b0;
      pop_cmp(tag);
   endtask

`ifdef PAD_AI_EN
   // One idle edge before the tick so the tracker has sampled the current y_pad
   task automatic ai_tick(input string tag);
      int c;
      @(negedge clk);
      @(negedge clk);
      c = m_y + HALF_H;
      timing_tick = 1'b1;
      model_tick((int'(ball_y) + DBAND) < c, int'(ball_y) > (c + DBAND), 3);
      push_exp();
      @(posedge clk); #1;
      timing_tick = 1'b0;
      pop_cmp(tag);
   endtask
`endif

   int exp1 [8] = '{313, 314, 315, 316, 318, 320, 322, 324};
   int prev_y;

   initial begin
      rst = 1'b1; timing_tick = 1'b0; up = 1'b0; down = 1'b0;
      recenter = 1'b0; ai_mode = 1'b0; ball_y = 10'd0;

      // Reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      push_exp();
      pop_cmp("reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: acceleration sequence while holding down
      for (int i = 0; i < 8; i++) begin
         tick("t1", 1'b0, 1'b1);
         check("t1_table", 32'(y_pad), 32'(exp1[i]));
      end

      // 2: recentre then hold down to the bottom limit, then hold three more ticks
      do_recenter("t2_rc");
      for (int i = 0; i < 300 && m_y != YHI; i++) begin
         tick("t2", 1'b0, 1'b1);
         check("t2_le_hi", 32'(y_pad <= 10'd621), 32'd1);
      end
      for (int i = 0; i < 3; i++) tick("t2_hold", 1'b0, 1'b1);
      check("t2_y621", 32'(y_pad), 32'd621);
      check("t2_atbot", 32'(at_bottom), 32'd1);

      // 3: reach the top, step back down to 4 at speed 1, then up 3, 2, 2
      for (int i = 0; i < 300 && m_y != YLO; i++) tick("t3_climb", 1'b1, 1'b0);
      tick("t3_rev", 1'b0, 1'b1);
      tick("t3_d1", 1'b0, 1'b1);
      tick("t3_d2", 1'b0, 1'b1);
      check("t3_at4", 32'(y_pad), 32'd4);
      tick("t3_stop", 1'b1, 1'b0);
      tick("t3_u1", 1'b1, 1'b0);
      check("t3_y3", 32'(y_pad), 32'd3);
      tick("t3_u2", 1'b1, 1'b0);
      check("t3_y2a", 32'(y_pad), 32'd2);
      tick("t3_u3", 1'b1, 1'b0);
      check("t3_y2b", 32'(y_pad), 32'd2);
      check("t3_attop", 32'(at_top), 32'd1);

      // 4: down five ticks, conflict tick, then up moves by exactly 1
      for (int i = 0; i < 5; i++) tick("t4_dn", 1'b0, 1'b1);
      prev_y = int'(y_pad);
      tick("t4_both", 1'b1, 1'b1);
      check("t4_nomove", 32'(y_pad), 32'(prev_y));
      check("t4_idle", 32'(moving), 32'd0);
      tick("t4_up", 1'b1, 1'b0);
      check("t4_step1", 32'(y_pad), 32'(prev_y - 1));

      // 5: recenter without a tick from far down, then async reset mid-move
      for (int i = 0; i < 100 && m_y < 480; i++) tick("t5_dn", 1'b0, 1'b1);
      do_recenter("t5_rc");
      check("t5_y312", 32'(y_pad), 32'd312);
      check("t5_mv0", 32'(moving), 32'd0);
      for (int i = 0; i < 3; i++) tick("t5_mv", 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_rst_y", 32'(y_pad), 32'd312);
      check("t5_rst_mv", 32'(moving), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      tick("t5_after", 1'b0, 1'b1);
      check("t5_first", 32'(y_pad), 32'd313);

`ifdef PAD_AI_EN
      // 6: AI chases a low ball with speed capped at 3, then holds inside the deadband
      up = 1'b0; down = 1'b0;
      do_recenter("t6_rc");
      ball_y  = 10'd500;
      ai_mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         prev_y = int'(y_pad);
         ai_tick("t6_chase");
      end
      check("t6_cap3", 32'(int'(y_pad) - prev_y), 32'd3);
      do_recenter("t6_rc2");
      ball_y = 10'd390;
      for (int i = 0; i < 4; i++) ai_tick("t6_dead");
      check("t6_still", 32'(y_pad), 32'd312);
      check("t6_mv0", 32'(moving), 32'd0);
      ai_mode = 1'b0;
`else
      // 6: without the AI build, ai_mode and ball_y have no effect
      ai_mode = 1'b1;
      ball_y  = 10'd0;
      prev_y  = int'(y_pad);
      tick("t6_stop", 1'b0, 1'b0);
      tick("t6_ign", 1'b0, 1'b0);
      check("t6_noai", 32'(y_pad), 32'(prev_y));
      ai_mode = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
